keypad_password_entry: RTL and testbench

KEYPAD_PASSWORD_ENTRY -- requirements
Module: keypad_password_entry

---
 rtl/keypad_password_entry_pkg.sv | 20 ++
 rtl/keypad_password_entry_timer.sv | 36 +++
 rtl/keypad_password_entry.sv | 144 ++++++++++++++
 tb/tb_keypad_password_entry.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_password_entry_pkg.sv
// Shared definitions for the keypad password entry block: FSM encoding and
// the special key codes, also used by controller-side benches.
package keypad_password_entry_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEND    = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [2:0] MAX_DIGITS = 3'd4;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_password_entry_timer.sv
// Inactivity timer: counts cycles while run is high and flags the last cycle
// of the idle window; restart or expiry brings it back to zero.
module entry_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || expired) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_password_entry.sv
// Collects four BCD digits from a keypad and presents them for HOLD_CYCLES
// cycles on ENTER; handles CLEAR, rejected keys and inactivity timeout.
module keypad_password_entry
    import keypad_password_entry_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HOLD_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] password_input,
    output logic        pwd_valid,
    output logic [2:0]  digit_count,
    output logic        entry_error,
    output logic        timeout
);
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_e        state_q, state_d;
    logic [15:0]   buf_q, buf_d;
    logic [2:0]    count_q, count_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [15:0]   pwd_q, pwd_d;
    logic          pwd_valid_q, pwd_valid_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;
    logic          tmo_expired;

    // Any key, and any cycle spent outside COLLECT, restarts the idle window.
    entry_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state_q == COLLECT),
        .restart(key_valid || (state_q != COLLECT)),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        count_d     = count_q;
        hold_d      = hold_q;
        pwd_d       = '0;
        pwd_valid_d = 1'b0;
        err_d       = 1'b0;
        tmo_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = COLLECT;
                    buf_d   = '0;
                    count_d = '0;
                end
            end
            COLLECT: begin
                if (!enable) begin
                    state_d = IDLE;
                    buf_d   = '0;
                    count_d = '0;
                end else if (key_valid) begin
                    if (is_digit(key_code)) begin
                        if (count_q < MAX_DIGITS) begin
                            buf_d   = {buf_q[11:0], key_code};
                            count_d = count_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        buf_d   = '0;
                        count_d = '0;
                    end else if (key_code == KEY_ENTER) begin
                        if (count_q == MAX_DIGITS) begin
                            state_d     = SEND;
                            hold_d      = '0;
                            pwd_d       = buf_q;
                            pwd_valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmo_expired) begin
                    buf_d   = '0;
                    count_d = '0;
                    tmo_d   = 1'b1;
                end
            end
            SEND: begin
                // Output registers are loaded one cycle ahead, so the last
                // hold count drops pwd_valid as the FSM enters DONE.
                if (hold_q == HOLD_LAST) begin
                    state_d = DONE;
                end else begin
                    hold_d      = hold_q + 1'b1;
                    pwd_d       = buf_q;
                    pwd_valid_d = 1'b1;
                end
            end
            DONE: begin
                buf_d   = '0;
                count_d = '0;
                hold_d  = '0;
                state_d = enable ? COLLECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            buf_q       <= '0;
            count_q     <= '0;
            hold_q      <= '0;
            pwd_q       <= '0;
            pwd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            pwd_q       <= pwd_d;
            pwd_valid_q <= pwd_valid_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign password_input = pwd_q;
    assign pwd_valid      = pwd_valid_q;
    assign digit_count    = count_q;
    assign entry_error    = err_q;
    assign timeout        = tmo_q;

endmodule

// File: tb/tb_keypad_password_entry.sv
// Scoreboard bench for keypad_password_entry: a digit-list reference model
// predicts events, a negedge monitor matches them as the DUT emits them.
module tb_keypad_password_entry;
    import keypad_password_entry_pkg::*;

    localparam int TMO  = 16;
    localparam int HOLD = 4;
    localparam int K_ERR = 0;
    localparam int K_TMO = 1;
    localparam int K_PWD = 2;

    typedef struct {
        int          kind;
        logic [15:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic [15:0] password_input;
    logic        pwd_valid;
    logic [2:0]  digit_count;
    logic        entry_error;
    logic        timeout;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        expq[$];
    int          mdig[$];
    bit          in_pwd = 0;
    int          run_len = 0;
    logic [15:0] held = '0;

    always #5 clk = ~clk;

    keypad_password_entry #(
        .TIMEOUT_CYCLES(TMO),
        .HOLD_CYCLES   (HOLD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .password_input(password_input),
        .pwd_valid     (pwd_valid),
        .digit_count   (digit_count),
        .entry_error   (entry_error),
        .timeout       (timeout)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic pop_check(input int kind, input logic [15:0] v, input string name);
        exp_t e;
        n_checks++;
        if (expq.size() == 0) begin
            n_errors++;
            $display("FAIL %s: unexpected event kind=%0d value=%h, nothing expected", name, kind, v);
        end else begin
            e = expq.pop_front();
            if (e.kind != kind || e.val != v) begin
                n_errors++;
                $display("FAIL %s: got kind=%0d value=%h, expected kind=%0d value=%h",
                         name, kind, v, e.kind, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void expect_ev(input int kind, input logic [15:0] v);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        expq.push_back(e);
    endfunction

    function automatic logic [15:0] model_word();
        return 16'(mdig[0] * 4096 + mdig[1] * 256 + mdig[2] * 16 + mdig[3]);
    endfunction

    // Monitor: every DUT output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            in_pwd  = 0;
            run_len = 0;
        end else begin
            if (entry_error) pop_check(K_ERR, 16'h0, "entry_error");
            if (timeout)     pop_check(K_TMO, 16'h0, "timeout");
            if (pwd_valid && !in_pwd) begin
                pop_check(K_PWD, password_input, "password");
                in_pwd  = 1;
                run_len = 1;
                held    = password_input;
            end else if (pwd_valid) begin
                run_len++;
                if (password_input != held) check("pwd_stable", password_input, held);
            end else if (in_pwd) begin
                check("pwd_hold_len", run_len, HOLD);
                check("pwd_zero_after", password_input, 0);
                in_pwd = 0;
            end
        end
    end

    // Press one key, update the model, and follow a SEND through to COLLECT.
    task automatic press(input logic [3:0] c);
        bit send;
        send = 0;
        if (c <= 4'd9) begin
            if (mdig.size() < 4) mdig.push_back(int'(c));
            else expect_ev(K_ERR, 16'h0);
        end else if (c == KEY_CLEAR) begin
            mdig.delete();
        end else if (c == KEY_ENTER) begin
            if (mdig.size() == 4) begin
                expect_ev(K_PWD, model_word());
                send = 1;
            end else begin
                expect_ev(K_ERR, 16'h0);
            end
        end else begin
            expect_ev(K_ERR, 16'h0);
        end
        key_valid = 1'b1;
        key_code  = c;
        tick();
        key_valid = 1'b0;
        if (send) begin
            check("enter_latency", pwd_valid, 1);
            key_valid = 1'b1;
            key_code  = 4'($urandom_range(0, 15));
            tick();
            key_valid = 1'b0;
            enable = 1'b0;
            tick();
            enable = 1'b1;
            repeat (3) tick();
            mdig.delete();
            check("count_after_send", digit_count, 0);
            check("pwd_low_after_send", pwd_valid, 0);
        end else begin
            check("digit_count", digit_count, mdig.size());
        end
    endtask

    initial begin
        logic [3:0] k;
        int r;
        #23;
        check("rst_pwd_valid", pwd_valid, 0);
        check("rst_password", password_input, 0);
        check("rst_count", digit_count, 0);
        check("rst_error", entry_error, 0);
        check("rst_timeout", timeout, 0);
        check("rst_state", int'(dut.state_q), int'(IDLE));
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_hold", int'(dut.state_q), int'(IDLE));
        enable = 1'b1;
        tick();
        check("collect_entry", int'(dut.state_q), int'(COLLECT));

        press(4'd3); press(4'd7); press(4'd6); press(4'd1); press(KEY_ENTER);

        press(4'd3); press(4'd7); press(4'd6); press(KEY_ENTER);
        check("short_enter_count", digit_count, 3);
        press(KEY_CLEAR);

        press(4'd3); press(4'd7); press(4'd6); press(4'd1); press(4'd9); press(KEY_ENTER);

        press(4'd5); press(4'd5); press(KEY_CLEAR);
        press(4'd3); press(4'd7); press(4'd6); press(4'd1); press(KEY_ENTER);

        press(4'hC); press(4'hF);

        press(4'd3); press(4'd7);
        expect_ev(K_TMO, 16'h0);
        repeat (TMO) tick();
        check("timeout_pulse", timeout, 1);
        check("timeout_count", digit_count, 0);
        mdig.delete();
        tick();
        check("timeout_one_cycle", timeout, 0);
        press(4'd3);
        repeat (TMO - 1) tick();
        press(4'd7);
        repeat (3) tick();
        check("no_timeout_on_key", timeout, 0);
        press(KEY_CLEAR);

        press(4'd2); press(4'd4);
        enable = 1'b0;
        tick();
        check("disable_clears", digit_count, 0);
        check("disable_idle", int'(dut.state_q), int'(IDLE));
        mdig.delete();
        enable = 1'b1;
        tick();

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      k = 4'($urandom_range(0, 9));
            else if (r < 70) k = KEY_CLEAR;
            else if (r < 88) k = KEY_ENTER;
            else             k = 4'($urandom_range(12, 15));
            press(k);
            if ($urandom_range(0, 19) == 0) begin
                enable = 1'b0;
                tick();
                check("rand_disable", digit_count, 0);
                mdig.delete();
                enable = 1'b1;
                tick();
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        press(KEY_CLEAR);
        for (int i = 0; i < 4; i++) press(4'($urandom_range(0, 9)));
        expect_ev(K_PWD, model_word());
        key_valid = 1'b1;
        key_code  = KEY_ENTER;
        tick();
        key_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("midsend_rst_valid", pwd_valid, 0);
        check("midsend_rst_pwd", password_input, 0);
        check("midsend_rst_count", digit_count, 0);
        check("midsend_rst_state", int'(dut.state_q), int'(IDLE));
        mdig.delete();
        #12;
        rst_n = 1'b1;
        tick();
        check("post_rst_collect", int'(dut.state_q), int'(COLLECT));
        repeat (3) tick();
        check("scoreboard_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
